// File: rtl/rgb_status_ctrl_pkg.sv
// Shared definitions for the RGB status controller: state encoding and default sizing.
package rgb_status_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  localparam int PWM_BITS_DEF  = 8;
  localparam int DUTY_DEF      = 16;
  localparam int BLINK_DIV_DEF = 23;

endpackage

// File: rtl/rgb_status_ctrl_timer.sv
// Free-running PWM counter and blink prescaler for the RGB status controller.
// Exposes the PWM count, the blink phase and a strobe on the last count of each PWM period.
module rgb_pwm_timer
  import rgb_status_ctrl_pkg::*;
#(
  parameter int PWM_BITS  = PWM_BITS_DEF,
  parameter int BLINK_DIV = BLINK_DIV_DEF
) (
  input  logic                clk,
  input  logic                reset,
  output logic [PWM_BITS-1:0] pwm_cnt_o,
  output logic                blink_phase_o,
  output logic                period_wrap_o
);

  logic [PWM_BITS-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [BLINK_DIV-1:0] blink_cnt_q, blink_cnt_d;
  logic                 blink_phase_q, blink_phase_d;

  always_comb begin
    pwm_cnt_d     = pwm_cnt_q + PWM_BITS'(1);
    blink_cnt_d   = blink_cnt_q + BLINK_DIV'(1);
    blink_phase_d = blink_phase_q;
    // Phase flips on the same cycle the prescaler rolls over to zero.
    if (&blink_cnt_q) begin
      blink_phase_d = ~blink_phase_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt_q     <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      pwm_cnt_q     <= pwm_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign pwm_cnt_o     = pwm_cnt_q;
  assign blink_phase_o = blink_phase_q;
  assign period_wrap_o = &pwm_cnt_q;

endmodule

// File: rtl/rgb_status_ctrl.sv
// Sticky busy/pass/fail verdict FSM driving the three RGB LED PWM inputs.
// Optional macro RGB_STATUS_BREATHE_EN: blue ramps its duty up and down while BUSY.
module rgb_status_ctrl
  import rgb_status_ctrl_pkg::*;
#(
  parameter int PWM_BITS  = PWM_BITS_DEF,
  parameter int DUTY      = DUTY_DEF,
  parameter int BLINK_DIV = BLINK_DIV_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_busy,
  input  logic       i_pass,
  input  logic       i_fail,
  input  logic       i_clear,
  output logic       o_led_r,
  output logic       o_led_g,
  output logic       o_led_b,
  output logic [1:0] o_state
);

  localparam logic [PWM_BITS-1:0] DUTY_W = PWM_BITS'(DUTY);

  state_e              state_q, state_d;
  logic                led_r_q, led_r_d;
  logic                led_g_q, led_g_d;
  logic                led_b_q, led_b_d;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_eff;
  logic                blink_phase;
  logic                period_wrap;
  logic                on;

  rgb_pwm_timer #(
    .PWM_BITS  (PWM_BITS),
    .BLINK_DIV (BLINK_DIV)
  ) u_timer (
    .clk           (clk),
    .reset         (reset),
    .pwm_cnt_o     (pwm_cnt),
    .blink_phase_o (blink_phase),
    .period_wrap_o (period_wrap)
  );

  // Verdicts are sticky: only clear leaves PASS/FAIL, and fail always wins.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if      (i_fail) state_d = ST_FAIL;
        else if (i_pass) state_d = ST_PASS;
        else if (i_busy) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if      (i_fail)  state_d = ST_FAIL;
        else if (i_pass)  state_d = ST_PASS;
        else if (!i_busy) state_d = ST_IDLE;
      end
      ST_PASS: begin
        if      (i_fail)  state_d = ST_FAIL;
        else if (i_clear) state_d = ST_IDLE;
      end
      ST_FAIL: begin
        if (i_clear && !i_fail) state_d = ST_IDLE;
      end
    endcase
  end

`ifdef RGB_STATUS_BREATHE_EN
  logic [PWM_BITS-1:0] ramp_q, ramp_d;
  logic                dir_up_q, dir_up_d;

  always_comb begin
    ramp_d   = ramp_q;
    dir_up_d = dir_up_q;
    if (state_d == ST_BUSY && state_q != ST_BUSY) begin
      ramp_d   = '0;
      dir_up_d = 1'b1;
    end else if (period_wrap) begin
      if (dir_up_q) begin
        ramp_d = ramp_q + PWM_BITS'(1);
        if (&ramp_d) dir_up_d = 1'b0;
      end else begin
        ramp_d = ramp_q - PWM_BITS'(1);
        if (ramp_d == '0) dir_up_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ramp_q   <= '0;
      dir_up_q <= 1'b1;
    end else begin
      ramp_q   <= ramp_d;
      dir_up_q <= dir_up_d;
    end
  end

  assign duty_eff = (state_q == ST_BUSY) ? ramp_q : DUTY_W;
`else
  logic unused_period_wrap;
  assign unused_period_wrap = period_wrap;
  assign duty_eff           = DUTY_W;
`endif

  always_comb begin
    on      = (pwm_cnt < duty_eff);
    led_r_d = 1'b0;
    led_g_d = 1'b0;
    led_b_d = 1'b0;
    unique case (state_q)
      ST_IDLE: ;
      ST_BUSY: led_b_d = on;
      ST_PASS: led_g_d = on;
      ST_FAIL: led_r_d = on & blink_phase;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      led_r_q <= 1'b0;
      led_g_q <= 1'b0;
      led_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      led_r_q <= led_r_d;
      led_g_q <= led_g_d;
      led_b_q <= led_b_d;
    end
  end

  assign o_state = state_q;
  assign o_led_r = led_r_q;
  assign o_led_g = led_g_q;
  assign o_led_b = led_b_q;

endmodule
